// File: rtl/ram_pkg.sv
// Shared widths, FSM state encoding and small helpers for the two-port RAM arbiter.
package ram_pkg;

  localparam int RAM_DATA_WIDTH     = 8;
  localparam int RAM_ADDR_BUS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ram_state_e;

  function automatic logic [1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side access port: request/write-enable/address/data in, grant/done/read data out.
interface ram_arbiter_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = RAM_DATA_WIDTH,
  parameter int ADDR_BUS_WIDTH = RAM_ADDR_BUS_WIDTH
);
  logic                      req;
  logic                      we;
  logic [ADDR_BUS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      gnt;
  logic                      done;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, done, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, done, rdata
  );
endinterface

// File: rtl/ram_arbiter_chk.sv
// Protocol checker: RAM enables mutually exclusive, and each grant followed by exactly one done two cycles later.
module ram_arbiter_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] gnt_i,
  input logic [1:0] done_i,
  input logic       rd_en_i,
  input logic       wr_en_i
);

  logic [1:0] pend1_q;
  logic [1:0] pend2_q;

  // Delay line of grants; reset discards in-flight accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend1_q <= 2'b00;
      pend2_q <= 2'b00;
    end else begin
      pend1_q <= gnt_i;
      pend2_q <= pend1_q;
    end
  end

  // Checked mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(rd_en_i && wr_en_i));
      assert (done_i == pend2_q);
    end
  end

endmodule

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin selector; ptr_i = 0 favours request 0 when both are pending.
module rr_arb2
  import ram_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  // One-hot grant; a lone request always wins regardless of the pointer.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single-port asynchronous-read RAM, one access in flight.
// Per access: gnt pulse, then one cycle of RAM enables, then done pulse (3 cycles).
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = RAM_DATA_WIDTH,
  parameter int ADDR_BUS_WIDTH = RAM_ADDR_BUS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ram_arbiter_if.slave              m0,
  ram_arbiter_if.slave              m1,
  output logic                      ram_read_en_o,
  output logic                      ram_write_en_o,
  output logic [ADDR_BUS_WIDTH-1:0] ram_address_loc_o,
  output logic [DATA_WIDTH-1:0]     ram_data_inbit_o,
  input  logic [DATA_WIDTH-1:0]     ram_data_outbit_i
);

  ram_state_e                state_q;
  logic                      ptr_q;
  logic                      owner_q;
  logic                      we_q;
  logic [1:0]                gnt_q;
  logic [1:0]                done_q;
  logic                      rd_en_q;
  logic                      wr_en_q;
  logic [ADDR_BUS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata0_q;
  logic [DATA_WIDTH-1:0]     rdata1_q;

  logic [1:0]                arb_gnt_s;
  logic                      we_d;
  logic [ADDR_BUS_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]     wdata_d;

  rr_arb2 u_rr_arb2 (
    .req_i ({m1.req, m0.req}),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s)
  );

  // Capture values of whichever requester the arbiter picks.
  always_comb begin
    we_d    = m0.we;
    addr_d  = m0.addr;
    wdata_d = m0.wdata;
    if (arb_gnt_s[1]) begin
      we_d    = m1.we;
      addr_d  = m1.addr;
      wdata_d = m1.wdata;
    end else begin
      we_d    = m0.we;
      addr_d  = m0.addr;
      wdata_d = m0.wdata;
    end
  end

  // Access FSM; enables are registered on leaving ISSUE so the RAM sees them in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_gnt_s != 2'b00) begin
            gnt_q   <= arb_gnt_s;
            owner_q <= arb_gnt_s[1];
            ptr_q   <= arb_gnt_s[0];
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            state_q <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          rd_en_q <= ~we_q;
          wr_en_q <= we_q;
          state_q <= WAIT;
        end
        WAIT: begin
          // Read data is only taken on reads, so a floating bus after a write never reaches rdata.
          if (!we_q) begin
            if (owner_q) begin
              rdata1_q <= ram_data_outbit_i;
            end else begin
              rdata0_q <= ram_data_outbit_i;
            end
          end
          done_q  <= idx_onehot(owner_q);
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0.gnt            = gnt_q[0];
  assign m1.gnt            = gnt_q[1];
  assign m0.done           = done_q[0];
  assign m1.done           = done_q[1];
  assign m0.rdata          = rdata0_q;
  assign m1.rdata          = rdata1_q;
  assign ram_read_en_o     = rd_en_q;
  assign ram_write_en_o    = wr_en_q;
  assign ram_address_loc_o = addr_q;
  assign ram_data_inbit_o  = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus queues expected grants, RAM ops and completions; a monitor pops and compares.
module tb_ram_arbiter;
  import ram_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct { int idx; int cyc; } gnt_t;
  typedef struct { int we; int addr; int data; int cyc; } op_t;
  typedef struct { int idx; int cyc; int rd0; int rd1; } done_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_rd, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [DW-1:0] mem [16];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mmem [16];
  int mr [2];
  gnt_t  gq[$];
  op_t   oq[$];
  done_t dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) m0_if ();
  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) m1_if ();

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .m0                (m0_if),
    .m1                (m1_if),
    .ram_read_en_o     (ram_rd),
    .ram_write_en_o    (ram_wr),
    .ram_address_loc_o (ram_addr),
    .ram_data_inbit_o  (ram_din),
    .ram_data_outbit_i (ram_dout)
  );

  ram_arbiter_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .gnt_i   ({m1_if.gnt, m0_if.gnt}),
    .done_i  ({m1_if.done, m0_if.done}),
    .rd_en_i (ram_rd),
    .wr_en_i (ram_wr)
  );

  // Asynchronous-read RAM; floats when not read.
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_din;
  assign ram_dout = ram_rd ? mem[ram_addr] : 'z;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every grant, RAM op and done must match the head of its queue.
  always @(negedge clk) begin : monitor
    gnt_t g;
    op_t o;
    done_t d;
    if (m0_if.gnt || m1_if.gnt) begin
      if (gq.size() == 0) chk("unexpected_gnt", 1, 0);
      else begin
        g = gq.pop_front();
        chk("gnt_both", int'(m0_if.gnt & m1_if.gnt), 0);
        chk("gnt_idx", int'(m1_if.gnt), g.idx);
        chk("gnt_cycle", cyc, g.cyc);
      end
    end
    if (ram_rd || ram_wr) begin
      chk("ram_en_excl", int'(ram_rd & ram_wr), 0);
      if (oq.size() == 0) chk("unexpected_ram_op", 1, 0);
      else begin
        o = oq.pop_front();
        chk("ram_op_we", int'(ram_wr), o.we);
        chk("ram_op_addr", int'(ram_addr), o.addr);
        if (o.we != 0) chk("ram_op_wdata", int'(ram_din), o.data);
        chk("ram_op_cycle", cyc, o.cyc);
      end
    end
    if (m0_if.done || m1_if.done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d = dq.pop_front();
        chk("done_idx", int'(m1_if.done), d.idx);
        chk("done_cycle", cyc, d.cyc);
        chk("m0_rdata", int'(m0_if.rdata), d.rd0);
        chk("m1_rdata", int'(m1_if.rdata), d.rd1);
      end
    end
  end

  task automatic expect_access(input int idx, input int we, input int addr, input int data,
                               input int c_gnt, input bit with_done);
    gnt_t g;
    op_t o;
    done_t d;
    g.idx = idx; g.cyc = c_gnt;
    o.we = we; o.addr = addr; o.data = data; o.cyc = c_gnt + 1;
    gq.push_back(g);
    oq.push_back(o);
    if (we != 0) mmem[addr] = data;
    else mr[idx] = mmem[addr];
    if (with_done) begin
      d.idx = idx; d.cyc = c_gnt + 2; d.rd0 = mr[0]; d.rd1 = mr[1];
      dq.push_back(d);
    end
  endtask

  task automatic drive(input int idx, input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    if (idx == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  task automatic wait_gnt(input int idx, input int budget);
    int got = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((idx == 0 && m0_if.gnt) || (idx == 1 && m1_if.gnt)) begin
        got = 1;
        break;
      end
    end
    chk("gnt_wait", got, 1);
  endtask

  task automatic hold_grants(input int n_gnt, input int budget);
    int seen = 0;
    for (int k = 0; k < budget && seen < n_gnt; k++) begin
      @(negedge clk);
      if (m0_if.gnt || m1_if.gnt) seen++;
    end
    chk("grant_count", seen, n_gnt);
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
  endtask

  task automatic single_access(input int idx, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    int c0;
    @(negedge clk);
    drive(idx, 1'b1, we, addr, wdata);
    c0 = cyc;
    expect_access(idx, int'(we), int'(addr), int'(wdata), c0 + 1, 1'b1);
    wait_gnt(idx, 8);
    drive(idx, 1'b0, we, addr, wdata);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h00;
      mmem[i] = 0;
    end
    mr[0] = 0;
    mr[1] = 0;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);

    repeat (2) @(negedge clk);
    chk("rst_gnt", int'({m1_if.gnt, m0_if.gnt}), 0);
    chk("rst_done", int'({m1_if.done, m0_if.done}), 0);
    chk("rst_enables", int'({ram_rd, ram_wr}), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_wdata", int'(ram_din), 0);
    chk("rst_rdata", int'({m1_if.rdata, m0_if.rdata}), 0);
    rst_n = 1'b1;

    // m0 write then m1 read of the same word.
    single_access(0, 1'b1, 4'd3, 8'hA5);
    single_access(1, 1'b0, 4'd3, 8'h00);

    // Both held: alternate m0, m1, m0, m1 three cycles apart.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'd5, 8'h3C);
    drive(1, 1'b1, 1'b0, 4'd5, 8'h00);
    c0 = cyc;
    expect_access(0, 1, 5, 8'h3C, c0 + 1, 1'b1);
    expect_access(1, 0, 5, 0, c0 + 4, 1'b1);
    expect_access(0, 1, 5, 8'h3C, c0 + 7, 1'b1);
    expect_access(1, 0, 5, 0, c0 + 10, 1'b1);
    hold_grants(4, 20);
    repeat (2) @(negedge clk);

    // m1 alone, held for four back-to-back reads.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 4'd3, 8'h00);
    c0 = cyc;
    for (int k = 0; k < 4; k++) expect_access(1, 0, 3, 0, c0 + 1 + 3 * k, 1'b1);
    hold_grants(4, 20);
    repeat (2) @(negedge clk);

    // m0 read aborted by reset while its RAM read is on the bus.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'd3, 8'h00);
    c0 = cyc;
    expect_access(0, 0, 3, 0, c0 + 1, 1'b0);
    wait_gnt(0, 8);
    drive(0, 1'b0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_enables", int'({ram_rd, ram_wr}), 0);
    chk("abort_done", int'({m1_if.done, m0_if.done}), 0);
    chk("abort_rdata0", int'(m0_if.rdata), 0);
    chk("abort_rdata1", int'(m1_if.rdata), 0);
    mr[0] = 0;
    mr[1] = 0;
    @(negedge clk);
    chk("abort_no_done", int'({m1_if.done, m0_if.done}), 0);
    rst_n = 1'b1;

    // After reset the pointer favours m0 again.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'd7, 8'h5A);
    drive(1, 1'b1, 1'b0, 4'd7, 8'h00);
    c0 = cyc;
    expect_access(0, 1, 7, 8'h5A, c0 + 1, 1'b1);
    expect_access(1, 0, 7, 0, c0 + 4, 1'b1);
    hold_grants(2, 12);
    repeat (4) @(negedge clk);

    chk("idle_addr_hold", int'(ram_addr), 7);
    chk("idle_enables", int'({ram_rd, ram_wr}), 0);
    chk("gnt_queue_empty", gq.size(), 0);
    chk("op_queue_empty", oq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
